// File: rtl/serializer_param.sv
// Parameterised parallel-to-serial shifter with back-to-back frames and abort.
// Define SER_PARITY_EN to add an optional even/odd parity bit after each frame.
module serializer_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  ser_en,
`ifdef SER_PARITY_EN
  input  logic                  par_en,
  input  logic                  par_typ,
`endif
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef SER_PARITY_EN
  localparam logic [1:0] S_PAR   = 2'd2;
`endif

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  head;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  load;
`ifdef SER_PARITY_EN
  logic                  pen_q, pen_d;
  logic                  pbit_q, pbit_d;
`endif

  assign head = LSB_FIRST ? sreg_q[0] : sreg_q[DATA_WIDTH-1];

  assign shifted = LSB_FIRST
                 ? {1'b0, sreg_q[DATA_WIDTH-1:1]}
                 : {sreg_q[DATA_WIDTH-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
`ifdef SER_PARITY_EN
    pen_d   = pen_q;
    pbit_d  = pbit_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (ser_en) load = 1'b1;
      end
      S_SHIFT: begin
        if (!ser_en) begin
          state_d = S_IDLE;
          sreg_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
`ifdef SER_PARITY_EN
          if (pen_q) begin
            state_d = S_PAR;
            sreg_d  = '0;
            cnt_d   = '0;
          end else begin
            load = 1'b1;
          end
`else
          load = 1'b1;
`endif
        end else begin
          sreg_d = shifted;
          cnt_d  = cnt_q + 1'b1;
        end
      end
`ifdef SER_PARITY_EN
      S_PAR: begin
        if (ser_en) load = 1'b1;
        else        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
      end
    endcase
    // Load covers both the IDLE start and the seamless back-to-back reload.
    if (load) begin
      state_d = S_SHIFT;
      sreg_d  = p_data;
      cnt_d   = '0;
`ifdef SER_PARITY_EN
      pen_d   = par_en;
      pbit_d  = (^p_data) ^ par_typ;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
`ifdef SER_PARITY_EN
      pen_q   <= 1'b0;
      pbit_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
`ifdef SER_PARITY_EN
      pen_q   <= pen_d;
      pbit_q  <= pbit_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);

  always_comb begin
    ser_data = 1'b0;
    ser_done = 1'b0;
    if (state_q == S_SHIFT) begin
      ser_data = head;
`ifdef SER_PARITY_EN
      ser_done = (cnt_q == LAST) && !pen_q;
`else
      ser_done = (cnt_q == LAST);
`endif
    end
`ifdef SER_PARITY_EN
    if (state_q == S_PAR) begin
      ser_data = pbit_q;
      ser_done = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_serializer_param.sv
// Bench for serializer_param: LSB-first and MSB-first instances side by side.
// Table vectors, directed corner cases and a random run against a queue model.
module tb_serializer_param;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          ser_en;
`ifdef SER_PARITY_EN
  logic          par_en;
  logic          par_typ;
`endif
  logic          sd_l, dn_l, bz_l;
  logic          sd_m, dn_m, bz_m;

  always #5 clk = ~clk;

  serializer_param #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1)) dut_l (
    .clk      (clk),
    .rst      (rst),
    .p_data   (p_data),
    .ser_en   (ser_en),
`ifdef SER_PARITY_EN
    .par_en   (par_en),
    .par_typ  (par_typ),
`endif
    .ser_data (sd_l),
    .ser_done (dn_l),
    .busy     (bz_l)
  );

  serializer_param #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0)) dut_m (
    .clk      (clk),
    .rst      (rst),
    .p_data   (p_data),
    .ser_en   (ser_en),
`ifdef SER_PARITY_EN
    .par_en   (par_en),
    .par_typ  (par_typ),
`endif
    .ser_data (sd_m),
    .ser_done (dn_m),
    .busy     (bz_m)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic el, input logic em,
                         input logic ed, input logic eb);
    chk({nm, ".lsb_data"}, sd_l, el);
    chk({nm, ".msb_data"}, sd_m, em);
    chk({nm, ".lsb_done"}, dn_l, ed);
    chk({nm, ".msb_done"}, dn_m, ed);
    chk({nm, ".lsb_busy"}, bz_l, eb);
    chk({nm, ".msb_busy"}, bz_m, eb);
  endtask

  task automatic chk_idle(input string nm);
    chk_all(nm, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sequences are written first-bit-at-MSB, straight from the bit lists.
  typedef struct {
    logic [7:0] word;
    logic [7:0] lsb_seq;
    logic [7:0] msb_seq;
  } vec_t;

  vec_t tbl[7];

  bit ql[$];
  bit qm[$];

  task automatic mload(input logic [DW-1:0] w, input logic pe, input logic pt);
    ql.delete();
    qm.delete();
    for (int i = 0; i < DW; i++) begin
      ql.push_back(w[i]);
      qm.push_back(w[DW-1-i]);
    end
    if (pe) begin
      ql.push_back((^w) ^ pt);
      qm.push_back((^w) ^ pt);
    end
  endtask

  task automatic mstep(input logic en, input logic [DW-1:0] w,
                       input logic pe, input logic pt);
    if (ql.size() > 0) begin
      if (!en) begin
        ql.delete();
        qm.delete();
      end else begin
        void'(ql.pop_front());
        void'(qm.pop_front());
        if (ql.size() == 0) mload(w, pe, pt);
      end
    end else if (en) begin
      mload(w, pe, pt);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    p_data = v.word;
    ser_en = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      nm = $sformatf("tbl%0d_b%0d", idx, k);
      chk_all(nm, v.lsb_seq[7-k], v.msb_seq[7-k], (k == 7), 1'b1);
      if (k == 2) p_data = ~v.word;
      if (k == 7) ser_en = 1'b0;
      tick();
    end
    chk_idle($sformatf("tbl%0d_idle", idx));
  endtask

`ifdef SER_PARITY_EN
  task automatic run_par(input logic typ, input logic exp_p);
    logic [7:0] w;
    w = 8'b10111001;
    p_data  = w;
    par_en  = 1'b1;
    par_typ = typ;
    ser_en  = 1'b1;
    tick();
    par_en = 1'b0;
    par_typ = ~typ;
    for (int k = 0; k < 8; k++) begin
      chk_all($sformatf("par%0d_b%0d", typ, k), w[k], w[7-k], 1'b0, 1'b1);
      tick();
    end
    ser_en = 1'b0;
    chk_all($sformatf("par%0d_pbit", typ), exp_p, exp_p, 1'b1, 1'b1);
    tick();
    chk_idle($sformatf("par%0d_idle", typ));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic       pe;
    logic       pt;

    tbl[0] = '{8'b10111001, 8'b10011101, 8'b10111001};
    tbl[1] = '{8'b10001001, 8'b10010001, 8'b10001001};
    tbl[2] = '{8'hFF,       8'hFF,       8'hFF};
    tbl[3] = '{8'h00,       8'h00,       8'h00};
    tbl[4] = '{8'hA5,       8'hA5,       8'hA5};
    tbl[5] = '{8'h01,       8'h80,       8'h01};
    tbl[6] = '{8'hC4,       8'h23,       8'hC4};

    rst    = 1'b0;
    ser_en = 1'b1;
    p_data = 8'hFF;
`ifdef SER_PARITY_EN
    par_en  = 1'b0;
    par_typ = 1'b0;
`endif
    #2;
    chk_idle("reset_async");
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset_held");

    // Release with ser_en high: the very next edge must load.
    p_data = 8'b10111001;
    rst    = 1'b1;
    tick();
    chk_all("rst_release_load", 1'b1, 1'b1, 1'b0, 1'b1);
    ser_en = 1'b0;
    tick();
    chk_idle("abort_first_bit");

    foreach (tbl[i]) run_vec(i, tbl[i]);

    // Back-to-back: A5 then 3C with no idle gap.
    a = 8'hA5;
    b = 8'h3C;
    p_data = a;
    ser_en = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      chk_all($sformatf("b2b_b%0d", k),
              (k < 8) ? a[k] : b[k-8],
              (k < 8) ? a[7-k] : b[15-k],
              (k == 7 || k == 15), 1'b1);
      if (k == 3)  p_data = 8'h00;
      if (k == 7)  p_data = b;
      if (k == 10) p_data = 8'hFF;
      if (k == 15) ser_en = 1'b0;
      tick();
    end
    chk_idle("b2b_idle");

    // Abort after four bits of FF.
    p_data = 8'hFF;
    ser_en = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk_all($sformatf("abort_b%0d", k), 1'b1, 1'b1, 1'b0, 1'b1);
      if (k == 3) ser_en = 1'b0;
      tick();
    end
    chk_idle("abort_idle");
    tick();
    chk_idle("abort_idle2");

    // Reset during bit 5 of a frame.
    p_data = 8'hFF;
    ser_en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) tick();
    chk_all("pre_rst_b5", 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("rst_mid");
    tick();
    chk_idle("rst_mid_held");
    ser_en = 1'b0;
    rst    = 1'b1;
    tick();
    chk_idle("rst_after");
    tick();
    chk_idle("rst_after2");
    p_data = 8'h01;
    ser_en = 1'b1;
    tick();
    chk_all("rst_reload", 1'b1, 1'b0, 1'b0, 1'b1);
    ser_en = 1'b0;
    tick();
    chk_idle("rst_reload_idle");

`ifdef SER_PARITY_EN
    run_par(1'b0, 1'b1);
    run_par(1'b1, 1'b0);
`endif

    // Random run against the queue model, starting from idle.
    ql.delete();
    qm.delete();
    for (int c = 0; c < 600; c++) begin
      ser_en = (($urandom % 8) != 0);
      p_data = 8'($urandom);
      pe = 1'b0;
      pt = 1'b0;
`ifdef SER_PARITY_EN
      pe = 1'($urandom);
      pt = 1'($urandom);
      par_en  = pe;
      par_typ = pt;
`endif
      @(posedge clk);
      mstep(ser_en, p_data, pe, pt);
      #1;
      chk_all($sformatf("rnd%0d", c),
              (ql.size() > 0) ? ql[0] : 1'b0,
              (qm.size() > 0) ? qm[0] : 1'b0,
              (ql.size() == 1),
              (ql.size() > 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
